// File: rtl/ntt_addr_gen_param.sv
// Address/control sequencer for NTT (CT), INTT (GS) and pointwise passes: one butterfly or
// element per cycle, with a delayed twiddle index and a delayed write-back address stream.
module ntt_addr_gen_param #(
  parameter int LOGN   = 8,
  parameter int LW     = 4,
  parameter int TF_LAT = 1,
  parameter int WR_LAT = 7
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [LW-1:0]   layers,
  input  logic            abort,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic            rd_en,
  output logic [LOGN-1:0] tf_addr,
  output logic [LW-1:0]   stage,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b,
  output logic            wen,
  output logic            busy,
  output logic            done
);

  localparam int CW = LOGN + 1;
  localparam int DW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [CW-1:0] ONE_C      = CW'(1);
  localparam logic [CW-1:0] N_C        = ONE_C << LOGN;
  localparam logic [LW-1:0] LOGN_LW    = LW'(LOGN);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(WR_LAT - 1);
  localparam logic [1:0]    M_NTT      = 2'b00;
  localparam logic [1:0]    M_INTT     = 2'b01;
  localparam logic [1:0]    M_PWM      = 2'b10;
  localparam logic [1:0]    M_PWA      = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [LW-1:0]   l_q, l_d;
  logic [CW-1:0]   j_q, j_d, s_q, s_d, len_q, len_d, k_q, k_d;
  logic [LW-1:0]   stage_q, stage_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d;
  logic [LOGN-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d, tf_iss_q, tf_iss_d;
  logic [LW-1:0]   stage_o_q, stage_o_d;

  logic [WR_LAT-1:0]           wen_pipe_q, wen_pipe_d;
  logic [WR_LAT-1:0][LOGN-1:0] wra_pipe_q, wra_pipe_d, wrb_pipe_q, wrb_pipe_d;

  logic [LW-1:0] l_eff;
  logic [CW-1:0] len_init_intt, k_init_intt, j_inc, s_next;
  logic          blk_end, lay_end, last_issue, fwd, flush;

  // Layer clamp, INTT start values and block/layer wrap detection for the current issue.
  always_comb begin
    if ((layers == {LW{1'b0}}) || (layers > LOGN_LW)) begin
      l_eff = LOGN_LW;
    end else begin
      l_eff = layers;
    end
    len_init_intt = ONE_C << (LOGN_LW - l_eff);
    k_init_intt   = (ONE_C << l_eff) - ONE_C;
    j_inc         = j_q + ONE_C;
    s_next        = s_q + (len_q << 1);
    blk_end       = (j_inc == (s_q + len_q));
    lay_end       = (s_next == N_C);
    fwd           = (mode_q == M_NTT);
    if (mode_q[1]) begin
      last_issue = (j_q == (N_C - ONE_C));
    end else begin
      last_issue = blk_end && lay_end && (stage_q == (l_q - LW'(1)));
    end
  end

  // Sequencer next state, counter stepping and next issue outputs.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    l_d     = l_q;
    j_d     = j_q;
    s_d     = s_q;
    len_d   = len_q;
    k_d     = k_q;
    stage_d = stage_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && abort) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_RUN;
          mode_d  = mode;
          l_d     = l_eff;
          j_d     = {CW{1'b0}};
          s_d     = {CW{1'b0}};
          stage_d = {LW{1'b0}};
          if (mode == M_INTT) begin
            len_d = len_init_intt;
            k_d   = k_init_intt;
          end else if (mode == M_NTT) begin
            len_d = N_C >> 1;
            k_d   = ONE_C;
          end else begin
            len_d = {CW{1'b0}};
            k_d   = {CW{1'b0}};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_issue) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_INIT;
        end else if (mode_q[1] || !blk_end) begin
          j_d = j_inc;
        end else if (!lay_end) begin
          s_d = s_next;
          j_d = s_next;
          k_d = fwd ? (k_q + ONE_C) : (k_q - ONE_C);
        end else begin
          s_d     = {CW{1'b0}};
          j_d     = {CW{1'b0}};
          stage_d = stage_q + LW'(1);
          len_d   = fwd ? (len_q >> 1) : (len_q << 1);
          k_d     = fwd ? (k_q + ONE_C) : (k_q - ONE_C);
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (drain_q == {DW{1'b0}}) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rd_en_d = (state_d == S_RUN);
    busy_d  = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d  = (state_d == S_DONE);
    if (rd_en_d) begin
      rd_a_d    = j_d[LOGN-1:0];
      rd_b_d    = mode_d[1] ? j_d[LOGN-1:0] : (j_d[LOGN-1:0] + len_d[LOGN-1:0]);
      stage_o_d = stage_d;
      case (mode_d)
        M_PWM:   tf_iss_d = j_d[LOGN-1:0];
        M_PWA:   tf_iss_d = {LOGN{1'b0}};
        default: tf_iss_d = k_d[LOGN-1:0];
      endcase
    end else begin
      rd_a_d    = {LOGN{1'b0}};
      rd_b_d    = {LOGN{1'b0}};
      stage_o_d = {LW{1'b0}};
      tf_iss_d  = {LOGN{1'b0}};
    end
  end

  // Write-back delay lines; an abort empties the wen line so no stale write fires.
  always_comb begin
    flush         = abort && (state_q != S_IDLE);
    wen_pipe_d[0] = flush ? 1'b0 : rd_en_q;
    wra_pipe_d[0] = rd_a_q;
    wrb_pipe_d[0] = rd_b_q;
    for (int i = 1; i < WR_LAT; i++) begin
      wen_pipe_d[i] = flush ? 1'b0 : wen_pipe_q[i-1];
      wra_pipe_d[i] = wra_pipe_q[i-1];
      wrb_pipe_d[i] = wrb_pipe_q[i-1];
    end
  end

  // All sequencer, issue and delay-line registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      mode_q     <= 2'b00;
      l_q        <= {LW{1'b0}};
      j_q        <= {CW{1'b0}};
      s_q        <= {CW{1'b0}};
      len_q      <= {CW{1'b0}};
      k_q        <= {CW{1'b0}};
      stage_q    <= {LW{1'b0}};
      drain_q    <= {DW{1'b0}};
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_a_q     <= {LOGN{1'b0}};
      rd_b_q     <= {LOGN{1'b0}};
      tf_iss_q   <= {LOGN{1'b0}};
      stage_o_q  <= {LW{1'b0}};
      wen_pipe_q <= '0;
      wra_pipe_q <= '0;
      wrb_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      l_q        <= l_d;
      j_q        <= j_d;
      s_q        <= s_d;
      len_q      <= len_d;
      k_q        <= k_d;
      stage_q    <= stage_d;
      drain_q    <= drain_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_a_q     <= rd_a_d;
      rd_b_q     <= rd_b_d;
      tf_iss_q   <= tf_iss_d;
      stage_o_q  <= stage_o_d;
      wen_pipe_q <= wen_pipe_d;
      wra_pipe_q <= wra_pipe_d;
      wrb_pipe_q <= wrb_pipe_d;
    end
  end

  generate
    if (TF_LAT == 0) begin : g_tf_comb
      assign tf_addr = tf_iss_q;
    end else begin : g_tf_pipe
      logic [TF_LAT-1:0][LOGN-1:0] tf_pipe_q, tf_pipe_d;

      // Twiddle index delay line.
      always_comb begin
        tf_pipe_d[0] = tf_iss_q;
        for (int i = 1; i < TF_LAT; i++) begin
          tf_pipe_d[i] = tf_pipe_q[i-1];
        end
      end

      // Twiddle delay registers.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          tf_pipe_q <= '0;
        end else begin
          tf_pipe_q <= tf_pipe_d;
        end
      end

      assign tf_addr = tf_pipe_q[TF_LAT-1];
    end
  endgenerate

  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign rd_en     = rd_en_q;
  assign stage     = stage_o_q;
  assign wr_addr_a = wra_pipe_q[WR_LAT-1];
  assign wr_addr_b = wrb_pipe_q[WR_LAT-1];
  assign wen       = wen_pipe_q[WR_LAT-1];
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ntt_addr_gen_param.sv
// Scoreboard bench for ntt_addr_gen_param: a small-N instance (LOGN=3, WR_LAT=2) and a
// default-parameter instance (LOGN=8, WR_LAT=7), both with TF_LAT=1.
module tb_ntt_addr_gen_param;

  localparam int WL3 = 2;
  localparam int TL3 = 1;
  localparam int WL8 = 7;
  localparam int TL8 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       start3, abort3, start8, abort8;
  logic [1:0] mode3, mode8;
  logic [3:0] layers3, layers8;

  logic [2:0] rd_a3, rd_b3, tf3, wa3, wb3;
  logic [3:0] stage3;
  logic       rd_en3, wen3, busy3, done3;
  logic [7:0] rd_a8, rd_b8, tf8, wa8, wb8;
  logic [3:0] stage8;
  logic       rd_en8, wen8, busy8, done8;

  ntt_addr_gen_param #(.LOGN(3), .LW(4), .TF_LAT(TL3), .WR_LAT(WL3)) dut3 (
    .clk(clk), .rstn(rstn), .start(start3), .mode(mode3), .layers(layers3), .abort(abort3),
    .rd_addr_a(rd_a3), .rd_addr_b(rd_b3), .rd_en(rd_en3), .tf_addr(tf3), .stage(stage3),
    .wr_addr_a(wa3), .wr_addr_b(wb3), .wen(wen3), .busy(busy3), .done(done3)
  );

  ntt_addr_gen_param dut8 (
    .clk(clk), .rstn(rstn), .start(start8), .mode(mode8), .layers(layers8), .abort(abort8),
    .rd_addr_a(rd_a8), .rd_addr_b(rd_b8), .rd_en(rd_en8), .tf_addr(tf8), .stage(stage8),
    .wr_addr_a(wa8), .wr_addr_b(wb8), .wen(wen8), .busy(busy8), .done(done8)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cur_sel = 0;
  int q_a[$], q_b[$], q_tf[$], q_st[$], q_tfd[$], q_wa[$], q_wb[$];

  int   obs_a, obs_b, obs_tf, obs_st, obs_wa, obs_wb;
  logic obs_rd_en, obs_wen, obs_busy, obs_done;

  always_comb begin
    if (cur_sel == 1) begin
      obs_a = int'(rd_a8); obs_b = int'(rd_b8); obs_tf = int'(tf8); obs_st = int'(stage8);
      obs_wa = int'(wa8); obs_wb = int'(wb8);
      obs_rd_en = rd_en8; obs_wen = wen8; obs_busy = busy8; obs_done = done8;
    end else begin
      obs_a = int'(rd_a3); obs_b = int'(rd_b3); obs_tf = int'(tf3); obs_st = int'(stage3);
      obs_wa = int'(wa3); obs_wb = int'(wb3);
      obs_rd_en = rd_en3; obs_wen = wen3; obs_busy = busy3; obs_done = done3;
    end
  end

  // Reference issue sequence, written as the textbook nested loops.
  task automatic model_push(input int logn, input int m, input int lay);
    int n, l, k, st, len;
    n  = 1 << logn;
    l  = (lay == 0 || lay > logn) ? logn : lay;
    st = 0;
    if (m == 0) begin
      k = 0;
      for (len = n / 2; len >= (n >> l); len = len / 2) begin
        for (int s = 0; s < n; s += 2 * len) begin
          k++;
          for (int j = s; j < s + len; j++) begin
            q_a.push_back(j); q_b.push_back(j + len); q_tf.push_back(k); q_st.push_back(st);
          end
        end
        st++;
      end
    end else if (m == 1) begin
      k = 1 << l;
      for (len = n >> l; len <= n / 2; len = len * 2) begin
        for (int s = 0; s < n; s += 2 * len) begin
          k--;
          for (int j = s; j < s + len; j++) begin
            q_a.push_back(j); q_b.push_back(j + len); q_tf.push_back(k); q_st.push_back(st);
          end
        end
        st++;
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        q_a.push_back(i); q_b.push_back(i); q_tf.push_back((m == 2) ? i : 0); q_st.push_back(0);
      end
    end
  endtask

  task automatic drive(input bit st, input int m, input int l);
    if (cur_sel == 1) begin
      start8 = st; mode8 = 2'(m); layers8 = 4'(l);
    end else begin
      start3 = st; mode3 = 2'(m); layers3 = 4'(l);
    end
  endtask

  // Start pulse; returns in the first cycle after acceptance with mode/layers scrambled.
  task automatic launch(input int m, input int l);
    drive(1'b1, m, l);
    @(negedge clk);
    drive(1'b0, 3 - m, 1);
  endtask

  // Pops the scoreboard cycle by cycle for an operation of cnt issues; optionally
  // raises start in the DONE cycle to chain the next operation.
  task automatic score_op(input int cnt, input string tag, input bit chain, input int nm, input int nl);
    int wl, tl, last_c, ea, eb, et, es, ewa, ewb;
    bit e_rd, e_busy, e_wen, e_done;
    wl = (cur_sel == 1) ? WL8 : WL3;
    tl = (cur_sel == 1) ? TL8 : TL3;
    last_c = chain ? (cnt + wl + 1) : (cnt + wl + 2);
    for (int c = 1; c <= last_c; c++) begin
      e_rd   = (c <= cnt);
      e_busy = (c <= cnt + wl);
      e_wen  = (c > wl) && (c <= cnt + wl);
      e_done = (c == cnt + wl + 1);
      ea = 0; eb = 0; et = 0; es = 0;
      if (e_rd) begin
        ea = q_a.pop_front(); eb = q_b.pop_front(); es = q_st.pop_front();
        q_tfd.push_back(q_tf.pop_front());
        q_wa.push_back(ea); q_wb.push_back(eb);
      end
      if ((c > tl) && (c <= cnt + tl)) et = q_tfd.pop_front();
      n_tests += 8;
      if (obs_rd_en !== e_rd) begin n_fail++; $display("FAIL %s rd_en c=%0d got %0b exp %0b", tag, c, obs_rd_en, e_rd); end
      if (obs_a !== ea) begin n_fail++; $display("FAIL %s rd_addr_a c=%0d got %0d exp %0d", tag, c, obs_a, ea); end
      if (obs_b !== eb) begin n_fail++; $display("FAIL %s rd_addr_b c=%0d got %0d exp %0d", tag, c, obs_b, eb); end
      if (obs_st !== es) begin n_fail++; $display("FAIL %s stage c=%0d got %0d exp %0d", tag, c, obs_st, es); end
      if (obs_tf !== et) begin n_fail++; $display("FAIL %s tf_addr c=%0d got %0d exp %0d", tag, c, obs_tf, et); end
      if (obs_busy !== e_busy) begin n_fail++; $display("FAIL %s busy c=%0d got %0b exp %0b", tag, c, obs_busy, e_busy); end
      if (obs_wen !== e_wen) begin n_fail++; $display("FAIL %s wen c=%0d got %0b exp %0b", tag, c, obs_wen, e_wen); end
      if (obs_done !== e_done) begin n_fail++; $display("FAIL %s done c=%0d got %0b exp %0b", tag, c, obs_done, e_done); end
      if (e_wen) begin
        ewa = q_wa.pop_front(); ewb = q_wb.pop_front();
        n_tests++;
        if ((obs_wa !== ewa) || (obs_wb !== ewb)) begin
          n_fail++;
          $display("FAIL %s wr_addr c=%0d got %0d/%0d exp %0d/%0d", tag, c, obs_wa, obs_wb, ewa, ewb);
        end
      end
      if (chain && (c == last_c)) drive(1'b1, nm, nl);
      @(negedge clk);
    end
    if (chain) drive(1'b0, 3 - nm, 1);
    n_tests++;
    if ((q_tfd.size() + q_wa.size()) != 0) begin
      n_fail++;
      $display("FAIL %s leftover_expected got %0d exp 0", tag, q_tfd.size() + q_wa.size());
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_tests += 2;
    if ({rd_a3, rd_b3, rd_en3, tf3, stage3, wa3, wb3, wen3, busy3, done3} !== 24'h0) begin
      n_fail++; $display("FAIL reset_dut3 got %h exp 0", {rd_a3, rd_b3, rd_en3, tf3, stage3, wa3, wb3, wen3, busy3, done3});
    end
    if ({rd_a8, rd_b8, rd_en8, tf8, stage8, wa8, wb8, wen8, busy8, done8} !== 48'h0) begin
      n_fail++; $display("FAIL reset_dut8 got %h exp 0", {rd_a8, rd_b8, rd_en8, tf8, stage8, wa8, wb8, wen8, busy8, done8});
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ntt3();
    cur_sel = 0;
    model_push(3, 0, 0); launch(0, 0); score_op(12, "ntt3_full", 1'b0, 0, 0);
  endtask

  task automatic test_intt3();
    cur_sel = 0;
    model_push(3, 1, 3); launch(1, 3); score_op(12, "intt3_full", 1'b0, 0, 0);
  endtask

  task automatic test_layer_clamp();
    cur_sel = 0;
    model_push(3, 0, 2); launch(0, 2); score_op(8, "ntt3_l2", 1'b0, 0, 0);
    model_push(3, 0, 9); launch(0, 9); score_op(12, "ntt3_l9", 1'b0, 0, 0);
    model_push(3, 1, 2); launch(1, 2); score_op(8, "intt3_l2", 1'b0, 0, 0);
  endtask

  task automatic test_ntt8();
    cur_sel = 1;
    model_push(8, 0, 7); launch(0, 7); score_op(896, "ntt8_l7", 1'b0, 0, 0);
    model_push(8, 1, 0); launch(1, 0); score_op(1024, "intt8_full", 1'b0, 0, 0);
    cur_sel = 0;
  endtask

  task automatic test_back_to_back();
    cur_sel = 0;
    model_push(3, 2, 0); model_push(3, 3, 0);
    launch(2, 0);
    score_op(8, "pwm3", 1'b1, 3, 0);
    score_op(8, "pwa3_b2b", 1'b0, 0, 0);
  endtask

  task automatic test_abort();
    cur_sel = 0;
    launch(0, 0);
    for (int c = 1; c <= 5; c++) begin
      n_tests++;
      if (rd_en3 !== 1'b1) begin n_fail++; $display("FAIL abort_pre rd_en c=%0d got %0b exp 1", c, rd_en3); end
      if (c < 5) @(negedge clk);
    end
    abort3 = 1'b1;
    @(negedge clk);
    abort3 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      n_tests++;
      if ({rd_en3, busy3, wen3, done3, rd_a3} !== 7'b0) begin
        n_fail++; $display("FAIL abort_quiet c=%0d got rd_en/busy/wen/done/a=%b exp 0", c, {rd_en3, busy3, wen3, done3, rd_a3});
      end
      @(negedge clk);
    end
    model_push(3, 0, 0); launch(0, 0); score_op(12, "ntt3_after_abort", 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid();
    cur_sel = 0;
    launch(0, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    drive(1'b1, 2, 0);
    @(negedge clk);
    n_tests++;
    if ({rd_a3, rd_b3, rd_en3, tf3, stage3, wa3, wb3, wen3, busy3, done3} !== 24'h0) begin
      n_fail++; $display("FAIL reset_mid got %h exp 0", {rd_a3, rd_b3, rd_en3, tf3, stage3, wa3, wb3, wen3, busy3, done3});
    end
    rstn = 1'b1;
    drive(1'b0, 0, 0);
    @(negedge clk);
    n_tests++;
    if ({busy3, rd_en3} !== 2'b00) begin
      n_fail++; $display("FAIL reset_start_ignored got busy/rd_en=%b exp 00", {busy3, rd_en3});
    end
    model_push(3, 3, 0); launch(3, 0); score_op(8, "pwa3_after_reset", 1'b0, 0, 0);
  endtask

  initial begin
    rstn = 1'b0;
    start3 = 1'b0; abort3 = 1'b0; mode3 = 2'b00; layers3 = 4'd0;
    start8 = 1'b0; abort8 = 1'b0; mode8 = 2'b00; layers8 = 4'd0;
    @(negedge clk);
    test_reset();
    test_ntt3();
    test_intt3();
    test_layer_clamp();
    test_ntt8();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
